// File: rtl/uart_tx.sv
// uart_tx: memory-mapped UART transmitter with a small TX FIFO.
// DATA (addr[2]=0) stores push bytes; STATUS (addr[2]=1) reads
// {occupancy[7:4], ovf, empty, full, busy}. Reading STATUS clears ovf.
// Build option: define UART_TX_PARITY_EN for 8E1 frames (default 8N1).
module uart_tx #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_rstrb_i,
    output logic [31:0] mem_rdata_o,
    input  logic [3:0]  mem_wmask_i,
    input  logic [31:0] mem_wdata_i,
    output logic        tx_o
);

    localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD;
    localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int unsigned PTR_W = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    // Elaboration-time parameter sanity checks
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx: CLK_FREQ_HZ / BAUD must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx: FIFO_DEPTH must be a power of two, at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic [7:0]         fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               fifo_empty_c;
    logic               fifo_full_c;
    logic               baud_zero_c;
    logic               push_c;
    logic               push_ok_c;
    logic               pop_c;
    logic [7:0]         head_c;
    logic [31:0]        status_c;
    logic               unused_c;

    assign fifo_empty_c = (count_q == '0);
    assign fifo_full_c  = (count_q == OCC_W'(FIFO_DEPTH));
    assign baud_zero_c  = (baud_q == '0);
    assign head_c       = fifo_q[rd_ptr_q];
    assign push_c       = mem_wmask_i[0] & ~mem_addr_i[2];
    // A full FIFO still accepts a byte when the FSM frees a slot this cycle
    assign push_ok_c    = push_c & (~fifo_full_c | pop_c);
    assign status_c     = {24'b0, 4'(count_q), ovf_q, fifo_empty_c, fifo_full_c,
                           (state_q != S_IDLE)};
    assign unused_c     = ^{mem_addr_i[31:3], mem_addr_i[1:0], mem_wdata_i[31:8],
                            mem_wmask_i[3:1]};

    // Baud-rate FSM: next state, shifter, bit counter and line level
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop_c     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty_c) begin
                    pop_c     = 1'b1;
                    shift_d   = head_c;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^head_c;
`endif
                    bit_idx_d = 3'd0;
                    baud_d    = CNT_W'(DIV - 1);
                    tx_d      = 1'b0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (baud_zero_c) begin
                    baud_d    = CNT_W'(DIV - 1);
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (baud_zero_c) begin
                    baud_d = CNT_W'(DIV - 1);
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_zero_c) begin
                    baud_d  = CNT_W'(DIV - 1);
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_zero_c) begin
                    if (!fifo_empty_c) begin
                        pop_c     = 1'b1;
                        shift_d   = head_c;
`ifdef UART_TX_PARITY_EN
                        parity_d  = ^head_c;
`endif
                        bit_idx_d = 3'd0;
                        baud_d    = CNT_W'(DIV - 1);
                        tx_d      = 1'b0;
                        state_d   = S_START;
                    end else begin
                        baud_d  = '0;
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointers, occupancy, sticky overflow and bus read data
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        rdata_d  = rdata_q;
        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok_c && !pop_c) begin
            count_d = count_q + OCC_W'(1);
        end else if (!push_ok_c && pop_c) begin
            count_d = count_q - OCC_W'(1);
        end
        if (mem_rstrb_i) begin
            rdata_d = mem_addr_i[2] ? status_c : 32'h0;
            if (mem_addr_i[2]) begin
                ovf_d = 1'b0;
            end
        end
        if (push_c && !push_ok_c) begin
            ovf_d = 1'b1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
        end
    end

    // FIFO storage; stale contents are unreachable once pointers reset
    always_ff @(posedge clk_i) begin
        if (push_ok_c) begin
            fifo_q[wr_ptr_q] <= mem_wdata_i[7:0];
        end
    end

    assign tx_o        = tx_q;
    assign mem_rdata_o = rdata_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx at DIV=4, FIFO_DEPTH=4.
module tb_uart_tx;

    localparam int unsigned DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * DIV;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] mem_addr_i;
    logic        mem_rstrb_i;
    logic [31:0] mem_rdata_o;
    logic [3:0]  mem_wmask_i;
    logic [31:0] mem_wdata_i;
    logic        tx_o;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx #(
        .CLK_FREQ_HZ(400),
        .BAUD       (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .mem_addr_i (mem_addr_i),
        .mem_rstrb_i(mem_rstrb_i),
        .mem_rdata_o(mem_rdata_o),
        .mem_wmask_i(mem_wmask_i),
        .mem_wdata_i(mem_wdata_i),
        .tx_o       (tx_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // One clock edge; strobes are single-cycle
    task automatic tick();
        @(posedge clk_i);
        #1;
        mem_wmask_i = 4'b0;
        mem_rstrb_i = 1'b0;
    endtask

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic write(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        mem_addr_i  = addr;
        mem_wmask_i = mask;
        mem_wdata_i = data;
        tick();
    endtask

    task automatic read_status(input logic [31:0] exp, input string tag);
        mem_addr_i  = 32'h4;
        mem_rstrb_i = 1'b1;
        tick();
        chk(mem_rdata_o, exp, tag);
    endtask

    // Expected line level for bit slot k of a frame carrying b
    function automatic logic exp_bit(input logic [7:0] b, input int unsigned k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[3'(k - 1)];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Check tx_o per cycle from frame cycle 'first'; optionally poll busy
    task automatic check_frame(input logic [7:0] b, input int unsigned first,
                               input bit chk_busy, input string tag);
        for (int unsigned i = first; i < FRAME; i++) begin
            if (chk_busy && i > 0) begin
                mem_addr_i  = 32'h4;
                mem_rstrb_i = 1'b1;
            end
            tick();
            chk({31'b0, tx_o}, {31'b0, exp_bit(b, i / DIV)}, $sformatf("%s tx[%0d]", tag, i));
            if (chk_busy && i > 0) begin
                chk({31'b0, mem_rdata_o[0]}, 32'd1, $sformatf("%s busy[%0d]", tag, i));
            end
        end
    endtask

    // Watch the line for n cycles and flag any low level
    task automatic check_idle(input int unsigned n, input string tag);
        logic seen_low;
        seen_low = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            tick();
            if (tx_o !== 1'b1) seen_low = 1'b1;
        end
        chk({31'b0, seen_low}, 32'd0, tag);
    endtask

    initial begin
        rst_i       = 1'b1;
        mem_addr_i  = 32'h0;
        mem_wmask_i = 4'b0;
        mem_wdata_i = 32'h0;
        mem_rstrb_i = 1'b0;

        // Reset
        repeat (3) tick();
        chk({31'b0, tx_o}, 32'd1, "reset tx");
        chk(mem_rdata_o, 32'h0, "reset rdata");
        rst_i = 1'b0;
        read_status(32'h4, "reset status");
        mem_addr_i  = 32'h0;
        mem_rstrb_i = 1'b1;
        tick();
        chk(mem_rdata_o, 32'h0, "data read");

        // STATUS writes and upper-lane-only writes do not push
        write(32'h4, 4'hF, 32'h55);
        write(32'h0, 4'b1110, 32'h1234_5678);
        chk({31'b0, tx_o}, 32'd1, "ignored writes tx");
        tick();
        read_status(32'h4, "ignored writes status");

        // Single byte
        write(32'h0, 4'b0001, 32'hA5);
        chk({31'b0, tx_o}, 32'd1, "single pre-start");
        check_frame(8'hA5, 0, 1'b0, "single");
        tick();
        read_status(32'h4, "single done");
        repeat (3) tick();
        chk(mem_rdata_o, 32'h4, "rdata hold");

        // Back-to-back
        mem_addr_i  = 32'h0;
        mem_wdata_i = 32'h00;
        mem_wmask_i = 4'b0001;
        tick();
        mem_wdata_i = 32'hFF;
        mem_wmask_i = 4'b0001;
        check_frame(8'h00, 0, 1'b1, "b2b0");
        check_frame(8'hFF, 0, 1'b1, "b2b1");
        tick();
        read_status(32'h4, "b2b done");

        // Overflow: 1 popped, 4 queued, 1 dropped
        for (int i = 0; i < 6; i++) write(32'h0, 4'b0001, 32'(32'h11 + i));
        read_status(32'h4B, "ovf status");
        read_status(32'h43, "ovf cleared");
        check_frame(8'h11, 7, 1'b0, "ovf f0");
        check_frame(8'h12, 0, 1'b0, "ovf f1");
        check_frame(8'h13, 0, 1'b0, "ovf f2");
        check_frame(8'h14, 0, 1'b0, "ovf f3");
        check_frame(8'h15, 0, 1'b0, "ovf f4");
        check_idle(2 * FRAME, "ovf no sixth frame");
        read_status(32'h4, "ovf done");

        // Full FIFO accepts a write on the popping STOP cycle
        for (int i = 0; i < 5; i++) write(32'h0, 4'b0001, 32'(32'h21 + i));
        check_frame(8'h21, 4, 1'b0, "full f0");
        mem_addr_i  = 32'h0;
        mem_wdata_i = 32'h26;
        mem_wmask_i = 4'b0001;
        check_frame(8'h22, 0, 1'b0, "full f1");
        check_frame(8'h23, 0, 1'b0, "full f2");
        check_frame(8'h24, 0, 1'b0, "full f3");
        check_frame(8'h25, 0, 1'b0, "full f4");
        check_frame(8'h26, 0, 1'b0, "full f5");
        tick();
        read_status(32'h4, "full no ovf");

        // Reset during DATA bit 3, with a byte still queued
        write(32'h0, 4'b0001, 32'hA5);
        write(32'h0, 4'b0001, 32'h3C);
        repeat (16) tick();
        chk({31'b0, tx_o}, 32'd0, "pre-reset bit3");
        rst_i = 1'b1;
        tick();
        chk({31'b0, tx_o}, 32'd1, "mid reset tx");
        chk(mem_rdata_o, 32'h0, "mid reset rdata");
        rst_i = 1'b0;
        read_status(32'h4, "mid reset status");
        check_idle(2 * FRAME, "mid reset no frames");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
